// File: rtl/ov7670_pattern_gen.sv
// ov7670_pattern_gen: synthetic OV7670 stream (PCLK, VSYNC, HREF, RGB565 bytes).
// Ports: clk, reset (sync, active-low), enable, pattern_sel[1:0] in;
//   pclk_out, vsync_out, href_out, data_out[7:0], frame_done, busy out.
// Macro OV7670_GEN_NOISE_EN: pattern 3 is a 16-bit LFSR (else 0000).
module ov7670_pattern_gen #(
  parameter int H_PIXELS    = 320,
  parameter int V_LINES     = 240,
  parameter int H_BLANK     = 144,
  parameter int VSYNC_LINES = 3,
  parameter int VBP_LINES   = 17,
  parameter int VFP_LINES   = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [1:0] pattern_sel,
  output logic       pclk_out,
  output logic       vsync_out,
  output logic       href_out,
  output logic [7:0] data_out,
  output logic       frame_done,
  output logic       busy
);

  localparam int L      = 2 * H_PIXELS + H_BLANK;
  localparam int VS_SL  = VSYNC_LINES * L;
  localparam int VB_SL  = VBP_LINES * L;
  localparam int VF_SL  = VFP_LINES * L;
  localparam int M1     = (VS_SL > VB_SL) ? VS_SL : VB_SL;
  localparam int MAX_SL = (M1 > VF_SL) ? M1 : VF_SL;
  localparam int CW     = $clog2(MAX_SL);
  localparam int YW     = $clog2(V_LINES);
  localparam int BW     = H_PIXELS / 8;
  localparam int BCW    = $clog2(BW + 1);

  typedef enum logic [2:0] {
    IDLE, VSYNC, VBACK, ACTIVE, HBLANK, VFRONT
  } state_t;

  state_t         st, st_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic [YW-1:0]  y, y_n;
  logic [1:0]     pat, pat_n;
  logic [2:0]     bar, bar_n;
  logic [BCW-1:0] bcnt, bcnt_n;
  logic           start;
  logic [7:2]     xs;
  logic           y4;
  logic [15:0]    px;
  logic           vs_n, hr_n, fd_n;
  logic [7:0]     byte_n;
`ifdef OV7670_GEN_NOISE_EN
  logic [15:0]    lfsr, lfsr_n;
  logic           fb;
`endif

  always_comb begin
    st_n   = st;
    cnt_n  = cnt;
    y_n    = y;
    pat_n  = pat;
    bar_n  = bar;
    bcnt_n = bcnt;
    start  = 1'b0;
`ifdef OV7670_GEN_NOISE_EN
    fb     = lfsr[15] ^ lfsr[14] ^ lfsr[12] ^ lfsr[3];
    lfsr_n = lfsr;
`endif
    unique case (st)
      IDLE: start = enable;
      VSYNC: begin
        if (cnt == CW'(VS_SL - 1)) begin
          st_n  = VBACK;
          cnt_n = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      VBACK: begin
        if (cnt == CW'(VB_SL - 1)) begin
          st_n   = ACTIVE;
          cnt_n  = '0;
          bar_n  = '0;
          bcnt_n = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      ACTIVE: begin
        if (cnt == CW'(2 * H_PIXELS - 1)) begin
          st_n  = HBLANK;
          cnt_n = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
        // odd byte closes a pixel: step bar tracker and noise source
        if (cnt[0]) begin
          if (bcnt == BCW'(BW - 1)) begin
            bcnt_n = '0;
            bar_n  = bar + 1'b1;
          end else begin
            bcnt_n = bcnt + 1'b1;
          end
`ifdef OV7670_GEN_NOISE_EN
          lfsr_n = {lfsr[14:0], fb};
`endif
        end
      end
      HBLANK: begin
        if (cnt == CW'(H_BLANK - 1)) begin
          cnt_n  = '0;
          bar_n  = '0;
          bcnt_n = '0;
          y_n    = y + 1'b1;
          st_n   = (y == YW'(V_LINES - 1)) ? VFRONT : ACTIVE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      VFRONT: begin
        if (cnt == CW'(VF_SL - 1)) begin
          if (enable) start = 1'b1;
          else        st_n  = IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: st_n = IDLE;
    endcase
    if (start) begin
      st_n  = VSYNC;
      cnt_n = '0;
      y_n   = '0;
      pat_n = pattern_sel;
`ifdef OV7670_GEN_NOISE_EN
      lfsr_n = 16'hACE1;
`endif
    end

    // outputs describe the slot being entered
    xs = 6'(cnt_n >> 3);
    y4 = 1'(y_n >> 4);
    px = 16'h0000;
    unique case (pat_n)
      2'd0: begin
        unique case (bar_n)
          3'd0: px = 16'hFFFF;
          3'd1: px = 16'hFFE0;
          3'd2: px = 16'h07FF;
          3'd3: px = 16'h07E0;
          3'd4: px = 16'hF81F;
          3'd5: px = 16'hF800;
          3'd6: px = 16'h001F;
          3'd7: px = 16'h0000;
        endcase
      end
      2'd1: px = {xs[7:3], xs[7:2], xs[7:3]};
      2'd2: px = (xs[4] ^ y4) ? 16'hFFFF : 16'h0000;
      2'd3: begin
`ifdef OV7670_GEN_NOISE_EN
        px = lfsr_n;
`else
        px = 16'h0000;
`endif
      end
    endcase
    vs_n   = (st_n == VSYNC);
    hr_n   = (st_n == ACTIVE);
    byte_n = hr_n ? (cnt_n[0] ? px[7:0] : px[15:8]) : 8'h00;
    fd_n   = (st == ACTIVE) && (cnt == CW'(2 * H_PIXELS - 1))
          && (y == YW'(V_LINES - 1));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      st         <= IDLE;
      cnt        <= '0;
      y          <= '0;
      pat        <= '0;
      bar        <= '0;
      bcnt       <= '0;
      pclk_out   <= 1'b0;
      vsync_out  <= 1'b0;
      href_out   <= 1'b0;
      data_out   <= 8'h00;
      frame_done <= 1'b0;
      busy       <= 1'b0;
`ifdef OV7670_GEN_NOISE_EN
      lfsr       <= 16'h0000;
`endif
    end else begin
      pclk_out   <= ~pclk_out;
      frame_done <= 1'b0;
      // everything advances on the clk where pclk_out falls
      if (pclk_out) begin
        st         <= st_n;
        cnt        <= cnt_n;
        y          <= y_n;
        pat        <= pat_n;
        bar        <= bar_n;
        bcnt       <= bcnt_n;
        vsync_out  <= vs_n;
        href_out   <= hr_n;
        data_out   <= byte_n;
        frame_done <= fd_n;
        busy       <= (st_n != IDLE);
`ifdef OV7670_GEN_NOISE_EN
        lfsr       <= lfsr_n;
`endif
      end
    end
  end

endmodule

// File: tb/tb_ov7670_pattern_gen.sv
// tb_ov7670_pattern_gen: slot-level reference model of the pattern
// generator, compared against the DUT every clk.
module tb_ov7670_pattern_gen;

  localparam int H  = 264;
  localparam int V  = 17;
  localparam int HB = 8;
  localparam int VS = 1;
  localparam int VB = 1;
  localparam int VF = 1;
  localparam int L  = 2 * H + HB;
  localparam int FS = (VS + VB + V + VF) * L;
`ifdef OV7670_GEN_NOISE_EN
  localparam logic [15:0] NOISE0 = 16'hACE1;
`else
  localparam logic [15:0] NOISE0 = 16'h0000;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic [1:0] pattern_sel = 2'd0;
  logic       pclk_out, vsync_out, href_out, frame_done, busy;
  logic [7:0] data_out;

  always #5 clk = ~clk;

  ov7670_pattern_gen #(
    .H_PIXELS(H), .V_LINES(V), .H_BLANK(HB),
    .VSYNC_LINES(VS), .VBP_LINES(VB), .VFP_LINES(VF)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .pattern_sel(pattern_sel), .pclk_out(pclk_out),
    .vsync_out(vsync_out), .href_out(href_out),
    .data_out(data_out), .frame_done(frame_done), .busy(busy)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

`ifdef OV7670_GEN_NOISE_EN
  logic [15:0] lf [0:H*V-1];
`endif
  logic [7:0] cap [0:V*2*H-1];

  function automatic logic [15:0] pix(input logic [1:0] p,
                                      input int x, input int y);
    int xl, r, g;
    case (p)
      2'd0: begin
        case (x / (H / 8))
          0: return 16'hFFFF;
          1: return 16'hFFE0;
          2: return 16'h07FF;
          3: return 16'h07E0;
          4: return 16'hF81F;
          5: return 16'hF800;
          6: return 16'h001F;
          default: return 16'h0000;
        endcase
      end
      2'd1: begin
        xl = x % 256;
        r = xl / 8;
        g = xl / 4;
        return 16'((r << 11) | (g << 5) | r);
      end
      2'd2: return (((x / 16) % 2) != ((y / 16) % 2)) ? 16'hFFFF : 16'h0000;
      default: begin
`ifdef OV7670_GEN_NOISE_EN
        return lf[y * H + x];
`else
        return 16'h0000;
`endif
      end
    endcase
  endfunction

  // model: frame is a flat run of FS slots, indexed by m_s
  bit         m_pclk = 0, m_run = 0, e_fd = 0, fall;
  int         m_s = 0;
  logic [1:0] m_pat = 0;
  bit         ev, eh;
  logic [7:0] ed;
  logic [15:0] p;
  int ln, pos;
  int rise_t [$];
  bit stats_ok = 0, pv = 0, ph = 0;
  int hcnt = 0, fcnt = 0, vlen = 0, hlen = 0;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (!reset) begin
      m_pclk = 0; m_run = 0; e_fd = 0; stats_ok = 0;
    end else begin
      fall = m_pclk;
      m_pclk = !m_pclk;
      e_fd = 0;
      if (fall) begin
        if (!m_run) begin
          if (enable) begin m_run = 1; m_s = 0; m_pat = pattern_sel; end
        end else begin
          m_s++;
          if (m_s == FS) begin
            if (enable) begin m_s = 0; m_pat = pattern_sel; end
            else m_run = 0;
          end
          if (m_run && m_s == (VS + VB + V - 1) * L + 2 * H) e_fd = 1;
        end
      end
    end
    ev = 0; eh = 0; ed = 8'h00;
    if (m_run) begin
      ln = m_s / L;
      pos = m_s % L;
      ev = (ln < VS);
      if (ln >= VS + VB && ln < VS + VB + V && pos < 2 * H) begin
        eh = 1;
        p = pix(m_pat, pos / 2, ln - VS - VB);
        ed = (pos % 2) ? p[7:0] : p[15:8];
      end
    end
    chk("outputs", {pclk_out, vsync_out, href_out, data_out, frame_done, busy},
        {m_pclk, ev, eh, ed, e_fd, m_run});
    if (eh) cap[(ln - VS - VB) * 2 * H + pos] = data_out;
    if (reset) begin
      if (vsync_out && !pv) begin
        rise_t.push_back(cyc);
        if (stats_ok) begin
          chk("href pulses per frame", hcnt, V);
          chk("frame_done per frame", fcnt, 1);
        end
        stats_ok = 1; hcnt = 0; fcnt = 0; vlen = 0;
      end
      if (vsync_out) vlen++;
      if (!vsync_out && pv) chk("vsync high clks", vlen, 2 * VS * L);
      if (href_out && !ph) begin hcnt++; hlen = 0; end
      if (href_out) hlen++;
      if (!href_out && ph) chk("href high clks", hlen, 4 * H);
      if (frame_done) fcnt++;
    end
    pv = vsync_out;
    ph = href_out;
  end

  int t_f1, t, tgt;

  initial begin
`ifdef OV7670_GEN_NOISE_EN
    lf[0] = 16'hACE1;
    for (int i = 1; i < H * V; i++)
      lf[i] = {lf[i-1][14:0], lf[i-1][15] ^ lf[i-1][14] ^ lf[i-1][12] ^ lf[i-1][3]};
`endif
    enable = 1'b1;
    pattern_sel = 2'd1;
    repeat (10) @(negedge clk);
    chk("reset outputs", {pclk_out, vsync_out, href_out, data_out, frame_done}, 0);
    chk("reset busy", busy, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("pclk after release", pclk_out, 1);
    chk("vsync before fall", vsync_out, 0);
    @(negedge clk);
    chk("pclk second clk", pclk_out, 0);
    chk("vsync first fall", vsync_out, 1);
    t_f1 = cyc;
    // pattern changes mid-frame must be ignored
    for (int k = 0; k < 4; k++) begin
      repeat ($urandom_range(100, 3000)) @(negedge clk);
      pattern_sel = 2'($urandom);
    end
    while (cyc < t_f1 + 2 * FS - 100) @(negedge clk);
    chk("grey px255 hi", cap[510], 8'hFF);
    chk("grey px255 lo", cap[511], 8'hFF);
    chk("grey px256 hi", cap[512], 8'h00);
    chk("grey px256 lo", cap[513], 8'h00);
    pattern_sel = 2'd2;
    tgt = t_f1 + 2 * FS + 2 * (VS + VB + $urandom_range(5, 12)) * L;
    while (cyc < tgt) @(negedge clk);
    enable = 1'b0;
    repeat ($urandom_range(10, 500)) @(negedge clk);
    pattern_sel = 2'($urandom);
    t = 0;
    while (busy && t < 2 * FS) begin @(negedge clk); t++; end
    chk("return to idle", busy, 0);
    chk("checker y0 x16 hi", cap[32], 8'hFF);
    chk("checker y0 x16 lo", cap[33], 8'hFF);
    chk("checker y16 x16 hi", cap[16 * 2 * H + 32], 8'h00);
    chk("checker y16 x16 lo", cap[16 * 2 * H + 33], 8'h00);
    if (rise_t.size() >= 2) chk("frame period", rise_t[1] - rise_t[0], 2 * FS);
    else chk("vsync rises seen", rise_t.size(), 2);
    repeat ($urandom_range(50, 300)) @(negedge clk);
    chk("idle busy", busy, 0);
    chk("idle vsync", vsync_out, 0);
    chk("idle rises", rise_t.size(), 2);
    pattern_sel = 2'd0;
    enable = 1'b1;
    t = 0;
    while (!vsync_out && t < 10) begin @(negedge clk); t++; end
    chk("restart vsync", vsync_out, 1);
    repeat (2 * 4 * L + 10) @(negedge clk);
    chk("bars b0", cap[0], 8'hFF);
    chk("bars b1", cap[1], 8'hFF);
    chk("bars b66", cap[66], 8'hFF);
    chk("bars b67", cap[67], 8'hE0);
    chk("bars b132", cap[132], 8'h07);
    chk("bars b133", cap[133], 8'hFF);
    chk("bars b396", cap[396], 8'h00);
    chk("bars b397", cap[397], 8'h1F);
    chk("bars b527", cap[527], 8'h00);
    reset = 1'b0;
    repeat ($urandom_range(3, 8)) @(negedge clk);
    chk("mid-frame reset", {pclk_out, vsync_out, href_out, data_out, frame_done, busy}, 0);
    pattern_sel = 2'd3;
    reset = 1'b1;
    repeat (2 * 3 * L + 20) @(negedge clk);
    chk("noise px0 hi", cap[0], NOISE0[15:8]);
    chk("noise px0 lo", cap[1], NOISE0[7:0]);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
